// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizing for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_WORDS = 512;
  localparam int unsigned ADRS_W     = $clog2(SRAM_WORDS);
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MAX_BURST  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of both requester ports plus the single-port SRAM bus.
interface sram_arbiter_if #(
  parameter int unsigned AW = sram_arbiter_pkg::ADRS_W,
  parameter int unsigned DW = sram_arbiter_pkg::DATA_W
);

  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_adrs;
  logic [DW-1:0] r0_di;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_do;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_adrs;
  logic [DW-1:0] r1_di;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_do;

  logic          sramEnable;
  logic          sramWE;
  logic [AW-1:0] sramAdrs;
  logic [DW-1:0] sramDi;
  logic [DW-1:0] sramDo;

  // Arbiter side
  modport slave (
    input  r0_req, r0_we, r0_adrs, r0_di,
    output r0_gnt, r0_rvalid, r0_do,
    input  r1_req, r1_we, r1_adrs, r1_di,
    output r1_gnt, r1_rvalid, r1_do,
    output sramEnable, sramWE, sramAdrs, sramDi,
    input  sramDo
  );

  // Requesters and SRAM side
  modport master (
    output r0_req, r0_we, r0_adrs, r0_di,
    input  r0_gnt, r0_rvalid, r0_do,
    output r1_req, r1_we, r1_adrs, r1_di,
    input  r1_gnt, r1_rvalid, r1_do,
    input  sramEnable, sramWE, sramAdrs, sramDi,
    output sramDo
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port burst arbiter in front of a single-port SRAM: one access per granted
// cycle, alternating ownership with a forced rotation after MAX_BURST grants.
module sram_arbiter #(
  parameter int unsigned MAX_BURST = sram_arbiter_pkg::MAX_BURST,
  parameter int unsigned ADRS_W    = sram_arbiter_pkg::ADRS_W
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  import sram_arbiter_pkg::*;

  localparam int unsigned   CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ROT = CNT_W'(MAX_BURST - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last;      // 1: port 1 owned most recently
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rvalid0;
  logic                r_rvalid1;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rot;
  logic                w_en_n;
  logic                w_we_n;
  logic [ADRS_W-1:0]   w_adrs;
  logic [DATA_W-1:0]   w_di;

  always_ff @(posedge clk) begin : state_reg
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin : next_state
    w_state_next = r_state;
    w_rot        = (r_cnt >= CNT_ROT);
    case (r_state)
      IDLE: begin
        if (bus.r0_req && bus.r1_req) w_state_next = r_last ? OWN0 : OWN1;
        else if (bus.r0_req)          w_state_next = OWN0;
        else if (bus.r1_req)          w_state_next = OWN1;
      end
      OWN0: begin
        if (!bus.r0_req)             w_state_next = bus.r1_req ? OWN1 : IDLE;
        else if (bus.r1_req && w_rot) w_state_next = OWN1;
      end
      OWN1: begin
        if (!bus.r1_req)             w_state_next = bus.r0_req ? OWN0 : IDLE;
        else if (bus.r0_req && w_rot) w_state_next = OWN0;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Grants are suppressed during reset so no access is issued in that cycle.
  always_comb begin : outputs
    w_gnt0 = (r_state == OWN0) && bus.r0_req && !reset;
    w_gnt1 = (r_state == OWN1) && bus.r1_req && !reset;
    w_en_n = 1'b1;
    w_we_n = 1'b1;
    w_adrs = '0;
    w_di   = '0;
    if (w_gnt0) begin
      w_en_n = 1'b0;
      w_we_n = !bus.r0_we;
      w_adrs = bus.r0_adrs;
      w_di   = bus.r0_di;
    end else if (w_gnt1) begin
      w_en_n = 1'b0;
      w_we_n = !bus.r1_we;
      w_adrs = bus.r1_adrs;
      w_di   = bus.r1_di;
    end
  end

  // Burst count, last owner and read-valid tracking.
  always_ff @(posedge clk) begin : aux_reg
    if (reset) begin
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      if (r_state == OWN0)      r_last <= 1'b0;
      else if (r_state == OWN1) r_last <= 1'b1;
      if ((w_state_next != r_state) && (w_state_next != IDLE))
        r_cnt <= '0;
      else if ((w_gnt0 || w_gnt1) && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_W'(1);
      r_rvalid0 <= w_gnt0 && !bus.r0_we;
      r_rvalid1 <= w_gnt1 && !bus.r1_we;
    end
  end

  assign bus.r0_gnt     = w_gnt0;
  assign bus.r1_gnt     = w_gnt1;
  assign bus.r0_rvalid  = r_rvalid0;
  assign bus.r1_rvalid  = r_rvalid1;
  assign bus.r0_do      = bus.sramDo;
  assign bus.r1_do      = bus.sramDo;
  assign bus.sramEnable = w_en_n;
  assign bus.sramWE     = w_we_n;
  assign bus.sramAdrs   = w_adrs;
  assign bus.sramDi     = w_di;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  sram_arbiter #(.MAX_BURST(16), .ADRS_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural SRAM: unwritten words read back a fixed address pattern
  logic [7:0] mem [512];
  bit         wr  [512];
  logic [7:0] sram_q;

  function automatic logic [7:0] init_val(input logic [8:0] a);
    return 8'(a * 13 + 7);
  endfunction

  always_ff @(posedge clk) begin
    if (!bus.sramEnable) begin
      if (!bus.sramWE) begin
        mem[bus.sramAdrs] <= bus.sramDi;
        wr[bus.sramAdrs]  <= 1'b1;
      end else begin
        sram_q <= wr[bus.sramAdrs] ? mem[bus.sramAdrs] : init_val(bus.sramAdrs);
      end
    end
  end
  assign bus.sramDo = sram_q;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] exp_mem [512];
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then update the model.
  task automatic step(input logic e0, input logic e1, input string tag);
    logic       xen, xwe;
    logic [8:0] xa;
    logic [7:0] xd;
    @(negedge clk);
    xen = !(e0 || e1);
    xwe = 1'b1;
    xa  = '0;
    xd  = '0;
    if (e0) begin
      xwe = !bus.r0_we; xa = bus.r0_adrs; xd = bus.r0_di;
    end else if (e1) begin
      xwe = !bus.r1_we; xa = bus.r1_adrs; xd = bus.r1_di;
    end
    chk(32'(bus.r0_gnt),     32'(e0),  {tag, ".r0_gnt"});
    chk(32'(bus.r1_gnt),     32'(e1),  {tag, ".r1_gnt"});
    chk(32'(bus.sramEnable), 32'(xen), {tag, ".sramEnable"});
    chk(32'(bus.sramWE),     32'(xwe), {tag, ".sramWE"});
    chk(32'(bus.sramAdrs),   32'(xa),  {tag, ".sramAdrs"});
    chk(32'(bus.sramDi),     32'(xd),  {tag, ".sramDi"});
    chk(32'(bus.r0_rvalid),  32'(sb0.size() != 0), {tag, ".r0_rvalid"});
    chk(32'(bus.r1_rvalid),  32'(sb1.size() != 0), {tag, ".r1_rvalid"});
    if (sb0.size() != 0) chk(32'(bus.r0_do), 32'(sb0.pop_front()), {tag, ".r0_do"});
    if (sb1.size() != 0) chk(32'(bus.r1_do), 32'(sb1.pop_front()), {tag, ".r1_do"});
    if (e0) begin
      if (bus.r0_we) exp_mem[bus.r0_adrs] = bus.r0_di;
      else           sb0.push_back(exp_mem[bus.r0_adrs]);
    end
    if (e1) begin
      if (bus.r1_we) exp_mem[bus.r1_adrs] = bus.r1_di;
      else           sb1.push_back(exp_mem[bus.r1_adrs]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) exp_mem[i] = init_val(9'(i));
    reset = 1'b1;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_adrs = '0; bus.r0_di = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_adrs = '0; bus.r1_di = '0;
    @(posedge clk);
    #1;
    step(0, 0, "rst0");
    step(0, 0, "rst1");
    reset = 1'b0;

    // Single read by port 0 at 0x005
    bus.r0_req = 1'b1; bus.r0_adrs = 9'h005;
    step(0, 0, "s1_arb");
    step(1, 0, "s1_gnt");
    bus.r0_req = 1'b0;
    step(0, 0, "s1_rv");

    // Reset after a port-0 ownership, then simultaneous requests
    reset = 1'b1;
    step(0, 0, "s3_rst0");
    step(0, 0, "s3_rst1");
    reset = 1'b0;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_adrs = 9'h010;
    step(0, 0, "s3_arb");
    bus.r0_we = 1'b1; bus.r0_adrs = 9'h010; bus.r0_di = 8'hC3;
    step(1, 0, "s3_w0");
    bus.r0_adrs = 9'h011; bus.r0_di = 8'h3C;
    step(1, 0, "s3_w1");
    bus.r0_we = 1'b0;
    step(1, 0, "s3_rd");
    bus.r0_req = 1'b0;
    step(0, 0, "s3_hand");
    step(0, 1, "s3_r1a");
    bus.r1_adrs = 9'h011;
    step(0, 1, "s3_r1b");
    bus.r1_req = 1'b0;
    step(0, 0, "s3_end0");
    step(0, 0, "s3_end1");

    // Port 1 write then read-back at the top address
    bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_adrs = 9'h1FF; bus.r1_di = 8'hA5;
    step(0, 0, "s2_arb");
    step(0, 1, "s2_wr");
    bus.r1_we = 1'b0;
    step(0, 1, "s2_rd");
    bus.r1_req = 1'b0;
    step(0, 0, "s2_rv");
    step(0, 0, "s2_idle");

    // Continuous dual requests: forced rotation every 16 grants
    bus.r0_req = 1'b1; bus.r1_req = 1'b1; bus.r0_we = 1'b0; bus.r1_we = 1'b0;
    step(0, 0, "rr_arb");
    for (int blk = 0; blk < 3; blk++) begin
      for (int k = 0; k < 16; k++) begin
        bus.r0_adrs = 9'(blk * 16 + k);
        bus.r1_adrs = 9'(256 + blk * 16 + k);
        step(blk % 2 == 0, blk % 2 == 1, $sformatf("rr_b%0d_%0d", blk, k));
      end
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    step(0, 0, "rr_end0");
    step(0, 0, "rr_end1");

    // Port 0 alone for 40 cycles: no rotation, counter saturates
    bus.r0_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.r0_we   = (i < 20);
      bus.r0_adrs = 9'(9'h040 + i % 20);
      bus.r0_di   = 8'(i + 8'h30);
      step(i != 0, 0, $sformatf("solo_%0d", i));
    end
    bus.r0_req = 1'b0;
    step(0, 0, "solo_end");

    // Port 0 owned last, so a dual request now favours port 1
    bus.r0_req = 1'b1; bus.r1_req = 1'b1; bus.r0_we = 1'b0; bus.r1_we = 1'b0;
    bus.r1_adrs = 9'h041;
    step(0, 0, "alt_arb");
    step(0, 1, "alt_g0");
    bus.r1_adrs = 9'h042;
    step(0, 1, "alt_g1");
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    step(0, 0, "alt_end");
    step(0, 0, "alt_idle");

    // Reset in the middle of a port-1 read burst
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_adrs = 9'h1FF;
    step(0, 0, "s6_arb");
    step(0, 1, "s6_g0");
    bus.r1_adrs = 9'h005;
    step(0, 1, "s6_g1");
    reset = 1'b1;
    step(0, 0, "s6_rst");
    reset = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_adrs = 9'h1FF;
    step(0, 0, "s6_post");
    step(1, 0, "s6_p0");
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    step(0, 0, "s6_end0");
    step(0, 0, "s6_end1");

    chk(32'(sb0.size()), 32'd0, "sb0_drained");
    chk(32'(sb1.size()), 32'd0, "sb1_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
